// File: rtl/alu_arbiter_if.sv
// Bundle of requester-side and ALU-side signals around the shared r0 ALU arbiter.
// The slave modport is the arbiter; the master modport is the environment (requesters + ALU).
interface alu_arbiter_if;
    logic       req0;
    logic       req1;
    logic [1:0] op0;
    logic [1:0] op1;
    logic [7:0] a0;
    logic [7:0] b0;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       done0;
    logic       done1;
    logic [7:0] res_hi;
    logic [7:0] res_lo;
    logic       err;
    logic       busy;
    logic       alu_en;
    logic [1:0] alu_state;
    logic [7:0] alu_value1;
    logic [7:0] alu_value2;
    logic       alu_ready;
    logic [7:0] alu_out1;
    logic [7:0] alu_out2;

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1, alu_ready, alu_out1, alu_out2,
        output done0, done1, res_hi, res_lo, err, busy, alu_en, alu_state, alu_value1, alu_value2
    );

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1, alu_ready, alu_out1, alu_out2,
        input  done0, done1, res_hi, res_lo, err, busy, alu_en, alu_state, alu_value1, alu_value2
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle ALU between two requesters.
// Every output is a register; the FSM computes the next value of each one.
module alu_arbiter #(
    parameter int TIMEOUT = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t     state_reg, state_next;
    logic       ptr_reg, ptr_next;
    logic       gnt_reg, gnt_next;
    logic [5:0] cnt_reg, cnt_next;
    logic       alu_en_reg, alu_en_next;
    logic       busy_reg, busy_next;
    logic       done0_reg, done0_next;
    logic       done1_reg, done1_next;
    logic       err_reg, err_next;
    logic [7:0] res_hi_reg, res_hi_next;
    logic [7:0] res_lo_reg, res_lo_next;
    logic [1:0] alu_state_reg, alu_state_next;
    logic [7:0] value1_reg, value1_next;
    logic [7:0] value2_reg, value2_next;
    logic       win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= 1'b0;
            gnt_reg       <= 1'b0;
            cnt_reg       <= '0;
            alu_en_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done0_reg     <= 1'b0;
            done1_reg     <= 1'b0;
            err_reg       <= 1'b0;
            res_hi_reg    <= '0;
            res_lo_reg    <= '0;
            alu_state_reg <= '0;
            value1_reg    <= '0;
            value2_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            gnt_reg       <= gnt_next;
            cnt_reg       <= cnt_next;
            alu_en_reg    <= alu_en_next;
            busy_reg      <= busy_next;
            done0_reg     <= done0_next;
            done1_reg     <= done1_next;
            err_reg       <= err_next;
            res_hi_reg    <= res_hi_next;
            res_lo_reg    <= res_lo_next;
            alu_state_reg <= alu_state_next;
            value1_reg    <= value1_next;
            value2_reg    <= value2_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        gnt_next       = gnt_reg;
        cnt_next       = cnt_reg;
        alu_en_next    = alu_en_reg;
        busy_next      = busy_reg;
        done0_next     = 1'b0;
        done1_next     = 1'b0;
        err_next       = err_reg;
        res_hi_next    = res_hi_reg;
        res_lo_next    = res_lo_reg;
        alu_state_next = alu_state_reg;
        value1_next    = value1_reg;
        value2_next    = value2_reg;
        // ptr_reg names the requester that wins a tie (the one not served last)
        win            = (bus.req0 && bus.req1) ? ptr_reg : bus.req1;

        case (state_reg)
            IDLE: begin
                alu_en_next = 1'b0;
                busy_next   = 1'b0;
                if (bus.req0 || bus.req1) begin
                    gnt_next       = win;
                    ptr_next       = ~win;
                    alu_state_next = win ? bus.op1 : bus.op0;
                    value1_next    = win ? bus.a1  : bus.a0;
                    value2_next    = win ? bus.b1  : bus.b0;
                    cnt_next       = '0;
                    alu_en_next    = 1'b1;
                    busy_next      = 1'b1;
                    state_next     = WAIT;
                end
            end
            WAIT: begin
                if (bus.alu_ready) begin
                    // Only MUL produces a meaningful second output word
                    res_hi_next = (alu_state_reg == 2'd2) ? bus.alu_out1 : 8'd0;
                    res_lo_next = (alu_state_reg == 2'd2) ? bus.alu_out2 : bus.alu_out1;
                    err_next    = 1'b0;
                    alu_en_next = 1'b0;
                    done0_next  = ~gnt_reg;
                    done1_next  = gnt_reg;
                    state_next  = DONE;
                end else if (cnt_reg == 6'(TIMEOUT - 1)) begin
                    res_hi_next = 8'd0;
                    res_lo_next = 8'd0;
                    err_next    = 1'b1;
                    alu_en_next = 1'b0;
                    done0_next  = ~gnt_reg;
                    done1_next  = gnt_reg;
                    state_next  = DONE;
                end else begin
                    cnt_next = cnt_reg + 6'd1;
                end
            end
            DONE: begin
                alu_en_next = 1'b0;
                busy_next   = 1'b0;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.done0      = done0_reg;
    assign bus.done1      = done1_reg;
    assign bus.res_hi     = res_hi_reg;
    assign bus.res_lo     = res_lo_reg;
    assign bus.err        = err_reg;
    assign bus.busy       = busy_reg;
    assign bus.alu_en     = alu_en_reg;
    assign bus.alu_state  = alu_state_reg;
    assign bus.alu_value1 = value1_reg;
    assign bus.alu_value2 = value2_reg;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural multi-cycle ALU plus hand-computed results.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arbiter_if bus ();
    alu_arbiter #(.TIMEOUT(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks   = 0;
    int failures = 0;
    int lat      = 3;
    bit never    = 1'b0;
    int acnt;

    // ALU model: ready pulses lat cycles after enable rises; garbage on out2 for non-MUL ops
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acnt <= 0; bus.alu_ready <= 1'b0; bus.alu_out1 <= 8'h00; bus.alu_out2 <= 8'h00;
        end else if (!bus.alu_en) begin
            acnt <= 0; bus.alu_ready <= 1'b0;
        end else begin
            acnt <= acnt + 1;
            bus.alu_ready <= (!never && (acnt + 1 == lat));
            case (bus.alu_state)
                2'd0: begin bus.alu_out1 <= bus.alu_value1 + bus.alu_value2; bus.alu_out2 <= 8'hA5; end
                2'd1: begin bus.alu_out1 <= bus.alu_value1 - bus.alu_value2; bus.alu_out2 <= 8'hA5; end
                2'd2: {bus.alu_out1, bus.alu_out2} <= {8'h00, bus.alu_value1} * {8'h00, bus.alu_value2};
                default: begin bus.alu_out1 <= 8'h00 - bus.alu_value1; bus.alu_out2 <= 8'hA5; end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Wait (bounded) for a done strobe, counting sampled cycles with alu_en high
    task automatic run_until_done(input int max, output int en_cyc, output logic d0, output logic d1);
        en_cyc = 0; d0 = 1'b0; d1 = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.alu_en) en_cyc++;
            if (bus.done0 || bus.done1) begin
                d0 = bus.done0; d1 = bus.done1;
                return;
            end
        end
        check("done_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic set_req(input bit id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        if (id) begin bus.req1 = 1'b1; bus.op1 = op; bus.a1 = a; bus.b1 = b; end
        else    begin bus.req0 = 1'b1; bus.op0 = op; bus.a0 = a; bus.b0 = b; end
    endtask

    int   en_cyc;
    int   gap;
    logic d0, d1;

    initial begin
        rst_n = 1'b0;
        bus.req0 = 0; bus.req1 = 0; bus.op0 = 0; bus.op1 = 0;
        bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
        repeat (3) @(negedge clk);
        check("rst_alu_en", bus.alu_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", {bus.done1, bus.done0}, 0);
        check("rst_res", {bus.res_hi, bus.res_lo, bus.err}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention from reset: req0 first, then req1
        set_req(0, 2'd0, 8'd10, 8'd3);
        set_req(1, 2'd1, 8'd100, 8'd1);
        run_until_done(50, en_cyc, d0, d1);
        check("pair1_first_done", {d1, d0}, 2'b01);
        check("pair1_first_res", {bus.res_hi, bus.res_lo}, 16'd13);
        bus.req0 = 1'b0;
        gap = 0;
        for (int i = 0; i < 20 && !bus.alu_en; i++) begin gap++; @(negedge clk); end
        check("pair1_en_gap_ge2", gap >= 2, 1);
        run_until_done(50, en_cyc, d0, d1);
        check("pair1_second_done", {d1, d0}, 2'b10);
        check("pair1_second_res", {bus.res_hi, bus.res_lo}, 16'h0063);
        bus.req1 = 1'b0;
        @(negedge clk);

        // Single ADD with issue latency and completion timing
        set_req(0, 2'd0, 8'd25, 8'd17);
        @(negedge clk);
        check("add_issue_en_busy", {bus.alu_en, bus.busy}, 2'b11);
        check("add_issue_operands", {bus.alu_state, bus.alu_value1, bus.alu_value2}, {2'd0, 8'd25, 8'd17});
        run_until_done(50, en_cyc, d0, d1);
        check("add_done", {d1, d0}, 2'b01);
        check("add_res", {bus.res_hi, bus.res_lo}, 16'd42);
        check("add_err", bus.err, 0);
        check("add_en_busy_in_done", {bus.alu_en, bus.busy}, 2'b01);
        bus.req0 = 1'b0;
        @(negedge clk);
        check("add_after_done", {bus.done0, bus.busy}, 2'b00);
        check("add_res_held", bus.res_lo, 8'd42);

        // Second simultaneous pair after req0 was served: req1 wins
        set_req(0, 2'd0, 8'd200, 8'd100);
        set_req(1, 2'd1, 8'd5, 8'd9);
        run_until_done(50, en_cyc, d0, d1);
        check("pair2_first_done", {d1, d0}, 2'b10);
        check("pair2_first_res", {bus.res_hi, bus.res_lo}, 16'h00FC);
        bus.req1 = 1'b0;
        run_until_done(50, en_cyc, d0, d1);
        check("pair2_second_done", {d1, d0}, 2'b01);
        check("pair2_second_res", {bus.res_hi, bus.res_lo}, 16'h002C);
        bus.req0 = 1'b0;
        @(negedge clk);

        // MUL split across res_hi/res_lo
        set_req(1, 2'd2, 8'd20, 8'd15);
        run_until_done(50, en_cyc, d0, d1);
        check("mul_done", {d1, d0}, 2'b10);
        check("mul_res", {bus.res_hi, bus.res_lo}, 16'h012C);
        bus.req1 = 1'b0;
        @(negedge clk);

        // Timeout: ALU never ready
        never = 1'b1;
        set_req(0, 2'd0, 8'd1, 8'd2);
        run_until_done(100, en_cyc, d0, d1);
        check("to_en_cycles", en_cyc, 32);
        check("to_done", {d1, d0}, 2'b01);
        check("to_err_res", {bus.err, bus.res_hi, bus.res_lo}, {1'b1, 16'h0000});
        bus.req0 = 1'b0;
        never = 1'b0;
        @(negedge clk);
        set_req(1, 2'd0, 8'd7, 8'd8);
        run_until_done(50, en_cyc, d0, d1);
        check("post_to_done", {d1, d0}, 2'b10);
        check("post_to_err_res", {bus.err, bus.res_hi, bus.res_lo}, {1'b0, 16'd15});
        bus.req1 = 1'b0;
        @(negedge clk);

        // req0 drops mid-op, queued req1 granted the cycle after DONE
        set_req(0, 2'd1, 8'd9, 8'd4);
        @(negedge clk);
        bus.req0 = 1'b0;
        set_req(1, 2'd2, 8'd16, 8'd16);
        run_until_done(50, en_cyc, d0, d1);
        check("drop_done", {d1, d0}, 2'b01);
        check("drop_res", {bus.res_hi, bus.res_lo}, 16'd5);
        @(negedge clk);
        check("drop_idle_gap", {bus.alu_en, bus.busy}, 2'b00);
        @(negedge clk);
        check("drop_req1_grant", {bus.alu_en, bus.alu_state, bus.alu_value1}, {1'b1, 2'd2, 8'd16});
        run_until_done(50, en_cyc, d0, d1);
        check("drop_req1_done", {d1, d0}, 2'b10);
        check("drop_req1_res", {bus.res_hi, bus.res_lo}, 16'h0100);
        bus.req1 = 1'b0;
        @(negedge clk);

        // Reset during WAIT of a NEG
        never = 1'b1;
        set_req(0, 2'd3, 8'd5, 8'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        #1;
        check("midrst_outputs", {bus.alu_en, bus.busy, bus.done0, bus.done1, bus.err},
              5'b00000);
        check("midrst_regs", {bus.alu_state, bus.alu_value1, bus.alu_value2, bus.res_hi, bus.res_lo},
              42'd0);
        @(negedge clk);
        check("midrst_no_done", {bus.done1, bus.done0}, 0);
        rst_n = 1'b1;
        never = 1'b0;
        @(negedge clk);
        check("postrst_no_done", {bus.done1, bus.done0, bus.busy}, 0);
        set_req(0, 2'd3, 8'd5, 8'd0);
        run_until_done(50, en_cyc, d0, d1);
        check("neg_done", {d1, d0}, 2'b01);
        check("neg_res", {bus.res_hi, bus.res_lo}, 16'h00FB);
        bus.req0 = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
